update_timing_gen: RTL

UPDATE_TIMING_GEN -- requirements
Module: update_timing_gen

---
 rtl/update_timing_gen_if.sv | 20 ++
 rtl/update_timing_gen.sv | 120 ++++++++++++
 2 files changed

// File: rtl/update_timing_gen_if.sv
// Update-timing generator bus: per-channel enable/period in, strobe/phase out.
// SYNC is present only when SYNC_EN is defined.
interface update_timing_gen_if #(
   parameter int WIDTH    = 13,
   parameter int CHANNELS = 4
);
   logic [CHANNELS-1:0]            EN;
   logic [CHANNELS-1:0][WIDTH-1:0] UPDATE_CYCLE;
   logic [CHANNELS-1:0]            UPDATE;
   logic [CHANNELS-1:0][WIDTH-1:0] PHASE;
`ifdef SYNC_EN
   logic                           SYNC;

   modport master (output EN, UPDATE_CYCLE, SYNC, input UPDATE, PHASE);
   modport slave  (input EN, UPDATE_CYCLE, SYNC, output UPDATE, PHASE);
`else
   modport master (output EN, UPDATE_CYCLE, input UPDATE, PHASE);
   modport slave  (input EN, UPDATE_CYCLE, output UPDATE, PHASE);
`endif
endinterface

// File: rtl/update_timing_gen.sv
// Multi-channel periodic update strobe generator with per-channel phase counter.
// Optional macro SYNC_EN adds the SYNC phase-realign strobe.
module update_timing_ch #(
   parameter int WIDTH = 13
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             run_ok,
   input  logic             en,
   input  logic [WIDTH-1:0] ucyc,
   input  logic             sync,
   output logic             upd,
   output logic [WIDTH-1:0] phase
);
   typedef enum logic {IDLE, RUN} state_t;

   state_t           state;
   logic [WIDTH-1:0] t, cyc;
   logic             start_ok;
   logic             wrap;

   assign start_ok = en && (ucyc != '0);
   // Unsigned WIDTH-bit compare; cyc is never 0 while RUN.
   assign wrap     = (t == cyc - WIDTH'(1));
   assign phase    = t;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state <= IDLE;
         t     <= '0;
         cyc   <= '0;
         upd   <= 1'b0;
      end else if (run_ok) begin
         if (sync) begin
            t     <= '0;
            cyc   <= ucyc;
            state <= start_ok ? RUN : IDLE;
            upd   <= start_ok;
         end else begin
            case (state)
               IDLE: begin
                  t   <= '0;
                  upd <= 1'b0;
                  if (start_ok) begin
                     state <= RUN;
                     cyc   <= ucyc;
                     upd   <= 1'b1;
                  end
               end
               RUN: begin
                  if (!en) begin
                     state <= IDLE;
                     t     <= '0;
                     upd   <= 1'b0;
                  end else if (wrap) begin
                     t <= '0;
                     if (ucyc == '0) begin
                        state <= IDLE;
                        upd   <= 1'b0;
                     end else begin
                        cyc <= ucyc;
                        upd <= 1'b1;
                     end
                  end else begin
                     t   <= t + WIDTH'(1);
                     upd <= 1'b0;
                  end
               end
               default: begin
                  state <= IDLE;
                  t     <= '0;
                  upd   <= 1'b0;
               end
            endcase
         end
      end
   end
endmodule

module update_timing_gen #(
   parameter int WIDTH    = 13,
   parameter int CHANNELS = 4
) (
   input logic                CLK,
   input logic                RST_N,
   update_timing_gen_if.slave bus
);
   // Reset release is held off two edges so all channels leave reset together.
   logic [1:0]                     rst_pipe;
   logic                           sync_w;
   logic [CHANNELS-1:0]            upd_w;
   logic [CHANNELS-1:0][WIDTH-1:0] phase_w;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) rst_pipe <= '0;
      else        rst_pipe <= {rst_pipe[0], 1'b1};
   end

`ifdef SYNC_EN
   assign sync_w = bus.SYNC;
`else
   assign sync_w = 1'b0;
`endif

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      update_timing_ch #(.WIDTH(WIDTH)) u_ch (
         .CLK    (CLK),
         .RST_N  (RST_N),
         .run_ok (rst_pipe[1]),
         .en     (bus.EN[g]),
         .ucyc   (bus.UPDATE_CYCLE[g]),
         .sync   (sync_w),
         .upd    (upd_w[g]),
         .phase  (phase_w[g])
      );
   end

   assign bus.UPDATE = upd_w;
   assign bus.PHASE  = phase_w;
endmodule
